delta_decoder: RTL and testbench
================================

DELTA_DECODER -- requirements
Module: delta_decoder

Interface
REQ-001 Parameters SHALL be: WIDTH, default 16, sample/delta width; FRAME_LEN, default 16, samples per frame (range 2..65535).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  delta word present.
REQ-005 in_ready  output  1  decoder accepts in_data this cycle.
REQ-006 in_first  input  1  qualifies in_data as absolute seed sample starting a new frame.
REQ-007 in_data  input  WIDTH  seed (when in_first) or two's-complement delta.
REQ-008 out_valid  output  1  reconstructed sample present.
REQ-009 out_ready  input  1  downstream accepts out_data.
REQ-010 out_data  output  WIDTH  reconstructed sample.
REQ-011 out_last  output  1  out_data is final sample of frame.
REQ-012 frame_err  output  1  one-cycle pulse on protocol violation.

Function
REQ-013 Input accept SHALL be in_valid && in_ready; output transfer SHALL be out_valid && out_ready.
REQ-014 in_ready SHALL equal !out_valid || out_ready (single registered output stage, full throughput, no combinational in_valid->out_valid path).
REQ-015 States SHALL be IDLE (no frame open) and RUN (frame open); acc (WIDTH) and cnt (16 bit) SHALL hold running sample and samples emitted in frame.
REQ-016 Accept with in_first in either state: acc<=in_data, emit in_data, cnt<=1, state<=RUN.
REQ-017 Accept without in_first in RUN: acc<=acc+in_data modulo 2^WIDTH (carry discarded), emit new acc, cnt<=cnt+1.
REQ-018 Sample emitted with cnt reaching FRAME_LEN SHALL carry out_last=1, and state SHALL return to IDLE.
REQ-019 Accept without in_first in IDLE: word consumed, no output, frame_err pulsed next cycle, state unchanged.
REQ-020 Accept with in_first in RUN before frame completion: frame_err pulsed next cycle, new frame starts per REQ-016; no out_last emitted for the truncated frame.
REQ-021 Latency SHALL be exactly one cycle from accept to out_valid=1 when output is not stalled.
REQ-022 out_data/out_last SHALL stay stable while out_valid && !out_ready.
REQ-023 out_valid SHALL drop the cycle after a transfer with no simultaneous accept; transfer plus accept in the same cycle SHALL load the next sample without a bubble.

Reset
REQ-024 rst SHALL asynchronously force: state=IDLE, acc=0, cnt=0, out_valid=0, out_data=0, out_last=0, frame_err=0; in_ready then reads 1.
REQ-025 Reset mid-frame SHALL discard the pending output and open frame; first post-reset accept must carry in_first to produce output.

Structure
REQ-026 Shared package SHALL hold WIDTH and FRAME_LEN defaults and the state encoding (IDLE=0, RUN=1).
REQ-027 Implementation SHALL be a single module; no sub-module is warranted.

Verification (FRAME_LEN=4, WIDTH=16)
REQ-028 Seed 100, deltas +5,-3,+10, out_ready=1 -> out 100,105,102,112 one cycle after each accept, out_last only on 112.
REQ-029 Seed 0xFFFE, delta +3 -> out 0xFFFE, 0x0001 (wrap, no flag).
REQ-030 out_ready=0 for 3 cycles mid-frame -> in_ready=0 while out_valid=1, out_data held, no words lost, sequence unchanged.
REQ-031 Delta 7 in IDLE -> no output, frame_err pulse; then seed 50 -> out 50.
REQ-032 Seed 10, delta +1, seed 200 -> out 10,11,200, frame_err pulse, no out_last; next 3 deltas of +1 -> 201,202,203 with out_last on 203.
REQ-033 rst asserted between accepts of a frame -> outputs zero immediately; post-reset delta without in_first -> frame_err, no output.

Source files
------------

// File: rtl/delta_decoder_pkg.sv
// Shared definitions for the delta decoder: default geometry, the
// state encoding and a small counter helper.
package delta_decoder_pkg;

    localparam int unsigned WIDTH_DEF     = 16;
    localparam int unsigned FRAME_LEN_DEF = 16;

    // Frame state encoding, kept as plain constants for legacy compatibility.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Sample counter increment, widened so a count of 65535 cannot wrap
    // before it is compared against the frame length.
    function automatic logic [16:0] cnt_inc(input logic [15:0] c);
        return {1'b0, c} + 17'd1;
    endfunction

endpackage

// File: rtl/delta_decoder_if.sv
// Stream interface of the delta decoder: delta input side, reconstructed
// sample output side and the protocol error pulse.
interface delta_decoder_if
    import delta_decoder_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
);

    logic             in_valid;
    logic             in_ready;
    logic             in_first;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             frame_err;

    // Decoder side.
    modport slave (
        input  in_valid, in_first, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last, frame_err
    );

    // Producer/consumer side.
    modport master (
        output in_valid, in_first, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last, frame_err
    );

endinterface

// File: rtl/delta_decoder.sv
// Delta decoder: reconstructs absolute samples from a seed word followed
// by two's-complement deltas, framed into FRAME_LEN-sample frames, with a
// single registered output stage.
module delta_decoder
    import delta_decoder_pkg::*;
#(
    parameter int unsigned WIDTH     = WIDTH_DEF,
    parameter int unsigned FRAME_LEN = FRAME_LEN_DEF
) (
    input  logic           clk,
    input  logic           rst,
    delta_decoder_if.slave bus
);

    logic [0:0]       state;
    logic [WIDTH-1:0] acc;
    logic [15:0]      cnt;

    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic             out_last_q;
    logic             frame_err_q;

    logic             in_ready;
    logic             accept;
    logic [WIDTH-1:0] sum;
    logic [16:0]      cnt_nxt;
    logic             last_nxt;

    // The output register can take a new sample when empty or draining.
    assign in_ready = !out_valid_q || bus.out_ready;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.frame_err = frame_err_q;

    // Accept qualification, running sum (carry dropped) and end-of-frame detect.
    always_comb begin
        accept   = bus.in_valid && in_ready;
        sum      = acc + bus.in_data;
        cnt_nxt  = cnt_inc(cnt);
        last_nxt = (cnt_nxt == 17'(FRAME_LEN));
    end

    // Frame state, accumulator and output stage update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            acc         <= '0;
            cnt         <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;

            // Drain first; a same-cycle accept below overrides this, so a
            // transfer plus accept reloads without a bubble.
            if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end

            if (accept) begin
                if (bus.in_first) begin
                    // A seed while a frame is still open truncates that frame.
                    if (state == ST_RUN) begin
                        frame_err_q <= 1'b1;
                    end
                    acc         <= bus.in_data;
                    out_data_q  <= bus.in_data;
                    out_valid_q <= 1'b1;
                    out_last_q  <= 1'b0;
                    cnt         <= 16'd1;
                    state       <= ST_RUN;
                end else if (state == ST_RUN) begin
                    acc         <= sum;
                    out_data_q  <= sum;
                    out_valid_q <= 1'b1;
                    out_last_q  <= last_nxt;
                    cnt         <= cnt_nxt[15:0];
                    if (last_nxt) begin
                        state <= ST_IDLE;
                    end
                end else begin
                    // Delta with no open frame: consumed and flagged only.
                    frame_err_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_delta_decoder.sv
// Self-checking bench for delta_decoder (WIDTH=16, FRAME_LEN=4): directed
// scenarios plus a randomized stream checked against a frame-level model.
module tb_delta_decoder;

    localparam int W  = 16;
    localparam int FL = 4;

    logic clk;
    logic rst;

    int tests = 0;
    int fails = 0;

    delta_decoder_if #(.WIDTH(W)) bus ();

    delta_decoder #(.WIDTH(W), .FRAME_LEN(FL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Snapshot {out_valid, out_last, frame_err, out_data}.
    function automatic logic [18:0] obs();
        return {bus.out_valid, bus.out_last, bus.frame_err, bus.out_data};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_first  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    // Present one word and hold it until accepted; returns 1 after the accepting edge.
    task automatic put(input bit first, input logic [15:0] d);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_first = first;
        bus.in_data  = d;
        while (!bus.in_ready && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) begin
            tests++;
            fails++;
            $display("FAIL put_timeout: in_ready=%0b after %0d cycles, required 1", bus.in_ready, n);
        end
        step();
        bus.in_valid = 1'b0;
        bus.in_first = 1'b0;
    endtask

    task automatic test_reset();
        logic [18:0] got;
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_first  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        #1 rst = 1'b1;
        #2;
        got = obs();
        tests++;
        if (got !== 19'd0) begin
            fails++;
            $display("FAIL reset_outputs: got %h, required %h", got, 19'd0);
        end
        tests++;
        if (bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready: got %b, required 1", bus.in_ready);
        end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        logic [18:0] exp_v [4];
        logic [15:0] d     [4];
        logic [18:0] got;
        d[0] = 16'd100;    exp_v[0] = {3'b100, 16'd100};
        d[1] = 16'd5;      exp_v[1] = {3'b100, 16'd105};
        d[2] = 16'hFFFD;   exp_v[2] = {3'b100, 16'd102};
        d[3] = 16'd10;     exp_v[3] = {3'b110, 16'd112};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            put(i == 0, d[i]);
            got = obs();
            tests++;
            if (got !== exp_v[i]) begin
                fails++;
                $display("FAIL basic_sample%0d: got %h, required %h", i, got, exp_v[i]);
            end
        end
        step();
        tests++;
        if (bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL basic_drop: out_valid=%b, required 0", bus.out_valid);
        end
    endtask

    task automatic test_wrap();
        logic [18:0] got;
        do_reset();
        put(1'b1, 16'hFFFE);
        got = obs();
        tests++;
        if (got !== {3'b100, 16'hFFFE}) begin
            fails++;
            $display("FAIL wrap_seed: got %h, required %h", got, {3'b100, 16'hFFFE});
        end
        put(1'b0, 16'd3);
        got = obs();
        tests++;
        if (got !== {3'b100, 16'h0001}) begin
            fails++;
            $display("FAIL wrap_sum: got %h, required %h", got, {3'b100, 16'h0001});
        end
    endtask

    task automatic test_stall();
        logic [18:0] got;
        do_reset();
        put(1'b1, 16'd100);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_first  = 1'b0;
        bus.in_data   = 16'd5;
        #1;
        for (int i = 0; i < 3; i++) begin
            got = obs();
            tests++;
            if (bus.in_ready !== 1'b0 || got !== {3'b100, 16'd100}) begin
                fails++;
                $display("FAIL stall_hold%0d: in_ready=%b out=%h, required 0 / %h",
                         i, bus.in_ready, got, {3'b100, 16'd100});
            end
            step();
        end
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        got = obs();
        tests++;
        if (got !== {3'b100, 16'd105}) begin
            fails++;
            $display("FAIL stall_release: got %h, required %h", got, {3'b100, 16'd105});
        end
        put(1'b0, 16'hFFFD);
        got = obs();
        tests++;
        if (got !== {3'b100, 16'd102}) begin
            fails++;
            $display("FAIL stall_next: got %h, required %h", got, {3'b100, 16'd102});
        end
        put(1'b0, 16'd10);
        got = obs();
        tests++;
        if (got !== {3'b110, 16'd112}) begin
            fails++;
            $display("FAIL stall_last: got %h, required %h", got, {3'b110, 16'd112});
        end
    endtask

    task automatic test_idle_delta();
        logic [18:0] got;
        do_reset();
        put(1'b0, 16'd7);
        got = obs();
        tests++;
        if (got !== {3'b001, 16'd0}) begin
            fails++;
            $display("FAIL idle_delta_err: got %h, required %h", got, {3'b001, 16'd0});
        end
        step();
        got = obs();
        tests++;
        if (got !== {3'b000, 16'd0}) begin
            fails++;
            $display("FAIL idle_delta_pulse: got %h, required %h", got, {3'b000, 16'd0});
        end
        put(1'b1, 16'd50);
        got = obs();
        tests++;
        if (got !== {3'b100, 16'd50}) begin
            fails++;
            $display("FAIL idle_then_seed: got %h, required %h", got, {3'b100, 16'd50});
        end
    endtask

    task automatic test_truncated();
        logic [18:0] exp_v [6];
        logic [15:0] d     [6];
        bit          f     [6];
        logic [18:0] got;
        f[0] = 1; d[0] = 16'd10;  exp_v[0] = {3'b100, 16'd10};
        f[1] = 0; d[1] = 16'd1;   exp_v[1] = {3'b100, 16'd11};
        f[2] = 1; d[2] = 16'd200; exp_v[2] = {3'b101, 16'd200};
        f[3] = 0; d[3] = 16'd1;   exp_v[3] = {3'b100, 16'd201};
        f[4] = 0; d[4] = 16'd1;   exp_v[4] = {3'b100, 16'd202};
        f[5] = 0; d[5] = 16'd1;   exp_v[5] = {3'b110, 16'd203};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            put(f[i], d[i]);
            got = obs();
            tests++;
            if (got !== exp_v[i]) begin
                fails++;
                $display("FAIL truncated_sample%0d: got %h, required %h", i, got, exp_v[i]);
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [18:0] got;
        do_reset();
        put(1'b1, 16'd100);
        put(1'b0, 16'd5);
        got = obs();
        tests++;
        if (got !== {3'b100, 16'd105}) begin
            fails++;
            $display("FAIL midreset_pre: got %h, required %h", got, {3'b100, 16'd105});
        end
        #2 rst = 1'b1;
        #1;
        got = obs();
        tests++;
        if (got !== 19'd0 || bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL midreset_async: out=%h in_ready=%b, required %h / 1", got, bus.in_ready, 19'd0);
        end
        #1 rst = 1'b0;
        step();
        put(1'b0, 16'd7);
        got = obs();
        tests++;
        if (got !== {3'b001, 16'd0}) begin
            fails++;
            $display("FAIL midreset_delta: got %h, required %h", got, {3'b001, 16'd0});
        end
    endtask

    task automatic test_random();
        logic [16:0] q [$];
        logic [16:0] e;
        bit          m_open = 0;
        int unsigned m_acc  = 0;
        int          m_cnt  = 0;
        bit          err_exp;
        bit          fire;
        do_reset();
        for (int cyc = 0; cyc < 800; cyc++) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) != 0) begin
                bus.in_valid = 1'b1;
                bus.in_first = ($urandom_range(0, 5) == 0) || (!m_open && $urandom_range(0, 1) == 1);
                bus.in_data  = 16'($urandom);
            end else begin
                bus.in_valid = 1'b0;
                bus.in_first = 1'b0;
            end
            #1;
            if (bus.out_valid && bus.out_ready) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL rand_spurious c%0d: out %h, required no sample", cyc, {bus.out_last, bus.out_data});
                end else begin
                    e = q.pop_front();
                    if ({bus.out_last, bus.out_data} !== e) begin
                        fails++;
                        $display("FAIL rand_sample c%0d: got %h, required %h", cyc, {bus.out_last, bus.out_data}, e);
                    end
                end
            end
            fire    = bus.in_valid && bus.in_ready;
            err_exp = 0;
            if (fire) begin
                if (bus.in_first) begin
                    err_exp = m_open;
                    m_acc   = bus.in_data;
                    m_cnt   = 1;
                    m_open  = 1;
                    q.push_back({1'b0, bus.in_data});
                end else if (m_open) begin
                    m_acc = (m_acc + bus.in_data) % 65536;
                    m_cnt++;
                    if (m_cnt == FL) m_open = 0;
                    q.push_back({m_cnt == FL, m_acc[15:0]});
                end else begin
                    err_exp = 1;
                end
            end
            step();
            tests++;
            if (bus.frame_err !== err_exp) begin
                fails++;
                $display("FAIL rand_err c%0d: got %b, required %b", cyc, bus.frame_err, err_exp);
            end
            tests++;
            if (bus.out_valid !== (q.size() != 0)) begin
                fails++;
                $display("FAIL rand_valid c%0d: got %b, required %b", cyc, bus.out_valid, q.size() != 0);
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        if (bus.out_valid) begin
            tests++;
            e = (q.size() != 0) ? q.pop_front() : 17'h1FFFF;
            if ({bus.out_last, bus.out_data} !== e) begin
                fails++;
                $display("FAIL rand_drain: got %h, required %h", {bus.out_last, bus.out_data}, e);
            end
        end
        step();
        tests++;
        if (bus.out_valid !== 1'b0 || q.size() != 0) begin
            fails++;
            $display("FAIL rand_end: out_valid=%b pending=%0d, required 0 / 0", bus.out_valid, q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_stall();
        test_idle_delta();
        test_truncated();
        test_reset_midframe();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
